// File: rtl/add_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple segment per stage, carry registered between stages.
// Latency WIDTH/SEG cycles; all stages hold together when the output slot is full and not taken.
module add_rca_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int LAT = WIDTH / SEG;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  // Subtract is a + ~b + ~borrow_in, so both b and the carry-in are inverted up front.
  assign w_b_eff   = op ? ~b : b;
  assign w_cin_eff = op ^ c_in;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    logic [SEG-1:0]       w_a_seg;
    logic [SEG-1:0]       w_b_seg;
    logic                 w_cy_in;
    logic                 w_vld_in;
    logic [SEG:0]         w_rc;
    logic [SEG-1:0]       w_sbit;
    logic [(k+1)*SEG-1:0] w_res_nxt;
    logic [(k+1)*SEG-1:0] r_res;
    logic                 r_cy;
    logic                 r_vld;

    if (k == 0) begin : g_head
      assign w_a_seg   = a[SEG-1:0];
      assign w_b_seg   = w_b_eff[SEG-1:0];
      assign w_cy_in   = w_cin_eff;
      assign w_vld_in  = in_valid;
      assign w_res_nxt = w_sbit;
    end else begin : g_body
      assign w_a_seg   = g_stage[k-1].g_skew.r_a_hi[SEG-1:0];
      assign w_b_seg   = g_stage[k-1].g_skew.r_b_hi[SEG-1:0];
      assign w_cy_in   = g_stage[k-1].r_cy;
      assign w_vld_in  = g_stage[k-1].r_vld;
      assign w_res_nxt = {w_sbit, g_stage[k-1].r_res};
    end

    always_comb begin
      w_rc    = '0;
      w_sbit  = '0;
      w_rc[0] = w_cy_in;
      for (int i = 0; i < SEG; i++) begin
        w_sbit[i]  = w_a_seg[i] ^ w_b_seg[i] ^ w_rc[i];
        w_rc[i+1]  = (w_a_seg[i] & w_b_seg[i]) | (w_rc[i] & (w_a_seg[i] ^ w_b_seg[i]));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_res <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_in;
        r_cy  <= w_rc[SEG];
        r_res <= w_res_nxt;
      end
    end

    // Operand bits not yet consumed ride along until their segment's stage.
    if (k < LAT-1) begin : g_skew
      logic [WIDTH-(k+1)*SEG-1:0] r_a_hi;
      logic [WIDTH-(k+1)*SEG-1:0] r_b_hi;
      logic [WIDTH-(k+1)*SEG-1:0] w_a_hi_nxt;
      logic [WIDTH-(k+1)*SEG-1:0] w_b_hi_nxt;

      if (k == 0) begin : g_ld0
        assign w_a_hi_nxt = a[WIDTH-1:SEG];
        assign w_b_hi_nxt = w_b_eff[WIDTH-1:SEG];
      end else begin : g_ldn
        assign w_a_hi_nxt = g_stage[k-1].g_skew.r_a_hi[WIDTH-k*SEG-1:SEG];
        assign w_b_hi_nxt = g_stage[k-1].g_skew.r_b_hi[WIDTH-k*SEG-1:SEG];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_adv) begin
          r_a_hi <= w_a_hi_nxt;
          r_b_hi <= w_b_hi_nxt;
        end
      end
    end

    if (k == LAT-1) begin : g_tail
      logic w_ovf;
      logic w_zero;
      logic r_ovf;
      logic r_zero;

      assign w_ovf  = (w_a_seg[SEG-1] == w_b_seg[SEG-1]) && (w_sbit[SEG-1] != w_a_seg[SEG-1]);
      assign w_zero = (w_res_nxt == '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_ovf  <= w_ovf;
          r_zero <= w_zero;
        end
      end
    end
  end

  assign out_valid = g_stage[LAT-1].r_vld;
  assign sum       = g_stage[LAT-1].r_res;
  assign c_out     = g_stage[LAT-1].r_cy;
  assign ovf       = g_stage[LAT-1].g_tail.r_ovf;
  assign zero      = g_stage[LAT-1].g_tail.r_zero;

endmodule

// File: tb/tb_add_rca_pipe.sv
// Bench for add_rca_pipe: directed corner cases, random streams with and without back-pressure, async reset mid-flight.
module tb_add_rca_pipe;
  localparam int W   = 16;
  localparam int SEG = 4;
  localparam int LAT = W / SEG;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;

  add_rca_pipe #(.WIDTH(W), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int           n_run = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           rdy_mode = 0;
  bit           lat_chk = 1'b1;
  bit           prev_stall = 1'b0;
  logic [W+2:0] exp_q[$];
  int           acc_q[$];
  logic [W+2:0] e_val;
  int           e_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_run++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: plain integer arithmetic; returns {c_out, ovf, zero, sum}.
  function automatic logic [W+2:0] ref_model(input logic o, input logic [W-1:0] x,
                                              input logic [W-1:0] y, input logic c);
    longint u, s;
    logic [W-1:0] r;
    logic co, ov;
    if (!o) begin
      u  = longint'(x) + longint'(y) + longint'(c);
      s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      co = (u >= (longint'(1) << W));
    end else begin
      u  = longint'(x) - longint'(y) - longint'(c);
      s  = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
      co = (u >= 0);
    end
    r  = u[W-1:0];
    ov = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
    return {co, ov, (r == '0), r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_vld", 32'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious", 32'(out_valid), 0);
        end else begin
          e_val = exp_q.pop_front();
          e_cyc = acc_q.pop_front();
          chk("result", 32'({c_out, ovf, zero, sum}), 32'(e_val));
          if (lat_chk) chk("latency", 32'(cyc - e_cyc), LAT);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(op, a, b, c_in));
        acc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int k;
    in_valid = 1'b1;
    op = o; a = x; b = y; c_in = c;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_flags", 32'({c_out, ovf, zero}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rdy", 32'(in_ready), 1);

    send(1'b0, 16'h0005, 16'h0032, 1'b0);
    drain();
    send(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    send(1'b1, 16'h8000, 16'h0001, 1'b0);
    send(1'b1, 16'h0003, 16'h0005, 1'b1);
    send(1'b1, 16'h0000, 16'h8000, 1'b0);
    drain();

    for (int i = 0; i < 20; i++) send_rand();
    drain();

    lat_chk  = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) send_rand();
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(1'b0, 16'h1111, 16'h2222, 1'b0);
    send(1'b1, 16'h4444, 16'h0001, 1'b0);
    send(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("stall_fill", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(out_valid), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_flags", 32'({c_out, ovf, zero}), 0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", 32'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_ghost", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(1'b0, 16'h1234, 16'h1111, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
